// File: rtl/dual_grant_dispatcher_if.sv
// Bundle between the grant dispatcher, its priority encoder and the two grant consumers.
// master = dispatcher side, slave = encoder/consumer side.
interface dual_grant_dispatcher_if #(
    parameter int N_REQ = 12,
    parameter int ID_W  = 4
);
    logic [N_REQ-1:0] req_in;
    logic             flush;
    logic [N_REQ-1:0] pend;
    logic [ID_W-1:0]  first;
    logic [ID_W-1:0]  second;
    logic             g0_valid;
    logic [ID_W-1:0]  g0_id;
    logic             g0_ready;
    logic             g1_valid;
    logic [ID_W-1:0]  g1_id;
    logic             g1_ready;
    logic             busy;
    logic             enc_err;

    modport master (
        input  req_in, flush, first, second, g0_ready, g1_ready,
        output pend, g0_valid, g0_id, g1_valid, g1_id, busy, enc_err
    );

    modport slave (
        output req_in, flush, first, second, g0_ready, g1_ready,
        input  pend, g0_valid, g0_id, g1_valid, g1_id, busy, enc_err
    );
endinterface

// File: rtl/dual_grant_dispatcher.sv
// Sticky request accumulator that offers the encoder's top two codes as two handshaked grants.
// Optional macro DISPATCH_ENC_CHECK_EN adds a sticky reference cross-check of the encoder (enc_err).
module dual_grant_dispatcher #(
    parameter int N_REQ = 12,
    parameter int ID_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dual_grant_dispatcher_if.master bus
);
    localparam int CNT_W = $clog2(N_REQ + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, FLUSH = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] pend_reg, pend_next, clr_mask;
    logic             g0_valid_reg, g0_valid_next, g1_valid_reg, g1_valid_next;
    logic [ID_W-1:0]  g0_id_reg, g0_id_next, g1_id_reg, g1_id_next;
    logic [ID_W-1:0]  first_q, second_q;
    logic [CNT_W-1:0] pop;
    logic             multi, acc0, acc1;

    // Encoder outputs are only trusted when they are in range and consistent with pend
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_REQ; i++) pop = pop + CNT_W'(pend_reg[i]);
    end
    assign multi    = (pop >= CNT_W'(2));
    assign first_q  = (pend_reg != '0 && bus.first >= ID_W'(1) && bus.first <= ID_W'(N_REQ))
                      ? bus.first : '0;
    assign second_q = (multi && bus.second >= ID_W'(1) && bus.second <= ID_W'(N_REQ)
                       && bus.second < bus.first) ? bus.second : '0;

    assign acc0 = (state_reg == OFFER) && g0_valid_reg && bus.g0_ready;
    assign acc1 = (state_reg == OFFER) && g1_valid_reg && bus.g1_ready;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_clr
            assign clr_mask[gi] = (acc0 && g0_id_reg == ID_W'(gi + 1))
                               || (acc1 && g1_id_reg == ID_W'(gi + 1));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (bus.flush)             state_next = FLUSH;
                   else if (first_q != '0)    state_next = OFFER;
            OFFER: if (bus.flush)             state_next = FLUSH;
                   else if (!(g0_valid_reg && !acc0) && !(g1_valid_reg && !acc1))
                                              state_next = IDLE;
            FLUSH:                            state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    always_comb begin
        pend_next     = pend_reg | bus.req_in;
        g0_valid_next = g0_valid_reg;
        g1_valid_next = g1_valid_reg;
        g0_id_next    = g0_id_reg;
        g1_id_next    = g1_id_reg;
        case (state_reg)
            IDLE: begin
                if (bus.flush) begin
                    pend_next     = '0;
                    g0_valid_next = 1'b0;
                    g1_valid_next = 1'b0;
                end else if (first_q != '0) begin
                    g0_id_next    = first_q;
                    g0_valid_next = 1'b1;
                    g1_id_next    = second_q;
                    g1_valid_next = (second_q != '0);
                end
            end
            OFFER: begin
                if (bus.flush) begin
                    pend_next     = '0;
                    g0_valid_next = 1'b0;
                    g1_valid_next = 1'b0;
                end else begin
                    // a request re-arriving on a bit being retired stays pending
                    pend_next     = (pend_reg & ~clr_mask) | bus.req_in;
                    g0_valid_next = g0_valid_reg & ~acc0;
                    g1_valid_next = g1_valid_reg & ~acc1;
                end
            end
            default: begin
                pend_next     = '0;
                g0_valid_next = 1'b0;
                g1_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg     <= '0;
            g0_valid_reg <= 1'b0;
            g1_valid_reg <= 1'b0;
            g0_id_reg    <= '0;
            g1_id_reg    <= '0;
        end else begin
            pend_reg     <= pend_next;
            g0_valid_reg <= g0_valid_next;
            g1_valid_reg <= g1_valid_next;
            g0_id_reg    <= g0_id_next;
            g1_id_reg    <= g1_id_next;
        end
    end

    assign bus.pend     = pend_reg;
    assign bus.g0_valid = g0_valid_reg;
    assign bus.g1_valid = g1_valid_reg;
    assign bus.g0_id    = g0_id_reg;
    assign bus.g1_id    = g1_id_reg;
    assign bus.busy     = (state_reg != IDLE);

`ifdef DISPATCH_ENC_CHECK_EN
    logic [ID_W-1:0] ref_first, ref_second;
    logic            enc_err_reg;

    // ascending scan: each set bit pushes the previous top code down to second
    always_comb begin
        ref_first  = '0;
        ref_second = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pend_reg[i]) begin
                ref_second = ref_first;
                ref_first  = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            enc_err_reg <= 1'b0;
        else if (state_reg == IDLE && pend_reg != '0
                 && (first_q != ref_first || second_q != ref_second))
            enc_err_reg <= 1'b1;
    end

    assign bus.enc_err = enc_err_reg;
`else
    assign bus.enc_err = 1'b0;
`endif
endmodule

// File: tb/tb_dual_grant_dispatcher.sv
// Bench for dual_grant_dispatcher: behavioural encoder, table vectors through a scoreboard,
// then hand sequences for backpressure, set-wins, flush, async reset and the encoder checker.
module tb_dual_grant_dispatcher;
    localparam int N_REQ = 12;
    localparam int ID_W  = 4;
`ifdef DISPATCH_ENC_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dual_grant_dispatcher_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus();

    dual_grant_dispatcher #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Encoder model: holds stale codes when it has nothing valid to report
    logic            force_bad = 1'b0;
    logic [ID_W-1:0] stale_first = 4'd9, stale_second = 4'd5;
    logic [ID_W-1:0] enc_f, enc_s;
    always_comb begin
        enc_f = '0;
        enc_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.pend[i]) begin
                enc_s = enc_f;
                enc_f = 4'(i + 1);
            end
        end
        bus.first  = (enc_f == '0) ? stale_first : enc_f;
        bus.second = (enc_s == '0) ? stale_second : enc_s;
        if (force_bad && bus.pend == 12'h010) bus.first = 4'd3;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [ID_W-1:0] g0_id;
        logic            g1_valid;
        logic [ID_W-1:0] g1_id;
    } exp_t;

    typedef struct {
        logic [N_REQ-1:0] req;
        exp_t             exp;
    } vec_t;

    function automatic vec_t mk(input logic [N_REQ-1:0] r, input logic [ID_W-1:0] a,
                                input logic v, input logic [ID_W-1:0] b);
        vec_t t;
        t.req          = r;
        t.exp.g0_id    = a;
        t.exp.g1_valid = v;
        t.exp.g1_id    = b;
        return t;
    endfunction

    function automatic exp_t mke(input logic [ID_W-1:0] a, input logic v, input logic [ID_W-1:0] b);
        exp_t e;
        e.g0_id    = a;
        e.g1_valid = v;
        e.g1_id    = b;
        return e;
    endfunction

    exp_t sb_q[$];
    exp_t sb_e;
    logic sb_en    = 1'b0;
    logic g0v_prev = 1'b0;

    // Scoreboard: every fresh offer on g0 must match the oldest pending expectation
    always @(negedge clk) begin
        if (sb_en && bus.g0_valid && !g0v_prev) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_unexpected: got g0_id %0d, expected no grant", bus.g0_id);
            end else begin
                sb_e = sb_q.pop_front();
                $display("grant g0_id=%0d g1_valid=%0b g1_id=%0d", bus.g0_id, bus.g1_valid, bus.g1_id);
                check("sb_g0_id", 32'(bus.g0_id), 32'(sb_e.g0_id));
                check("sb_g1_valid", 32'(bus.g1_valid), 32'(sb_e.g1_valid));
                if (sb_e.g1_valid) check("sb_g1_id", 32'(bus.g1_id), 32'(sb_e.g1_id));
            end
        end
        g0v_prev <= bus.g0_valid;
    end

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(bus.busy == 1'b0 && bus.pend == '0 && !bus.g0_valid && !bus.g1_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got busy=%0b pend=%0h, expected idle within 50 cycles",
                     name, bus.busy, bus.pend);
        end
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        vecs[0] = mk(12'h801, 4'd12, 1'b1, 4'd1);
        vecs[1] = mk(12'h001, 4'd1,  1'b0, 4'd0);
        vecs[2] = mk(12'h0C0, 4'd8,  1'b1, 4'd7);
        vecs[3] = mk(12'h800, 4'd12, 1'b0, 4'd0);
        vecs[4] = mk(12'h006, 4'd3,  1'b1, 4'd2);
        vecs[5] = mk(12'h030, 4'd6,  1'b1, 4'd5);
        vecs[6] = mk(12'h402, 4'd11, 1'b1, 4'd2);
        vecs[7] = mk(12'h003, 4'd2,  1'b1, 4'd1);

        bus.req_in   = '0;
        bus.flush    = 1'b0;
        bus.g0_ready = 1'b0;
        bus.g1_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_pend", 32'(bus.pend), 32'h0);
        check("rst_g0_valid", 32'(bus.g0_valid), 32'h0);
        check("rst_g1_valid", 32'(bus.g1_valid), 32'h0);
        check("rst_g0_id", 32'(bus.g0_id), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_enc_err", 32'(bus.enc_err), 32'h0);
        reset_n = 1'b1;

        // stale first=9 with pend=0 must not be dispatched
        repeat (3) @(negedge clk);
        check("stale_first_busy", 32'(bus.busy), 32'h0);
        check("stale_first_g0_valid", 32'(bus.g0_valid), 32'h0);

        // table vectors through the scoreboard, consumers always ready
        sb_en        = 1'b1;
        bus.g0_ready = 1'b1;
        bus.g1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_in = vecs[i].req;
            sb_q.push_back(vecs[i].exp);
            @(negedge clk);
            bus.req_in = '0;
            wait_idle("vec");
        end
        // three requests: a pair, then the leftover as a single grant
        @(negedge clk);
        bus.req_in = 12'h00E;
        sb_q.push_back(mke(4'd4, 1'b1, 4'd3));
        sb_q.push_back(mke(4'd2, 1'b0, 4'd0));
        @(negedge clk);
        bus.req_in = '0;
        wait_idle("triple");
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        sb_en = 1'b0;

        // backpressure: g1 retires first, g0 held
        bus.g0_ready = 1'b0;
        bus.g1_ready = 1'b1;
        bus.req_in   = 12'h0C0;
        @(negedge clk);
        bus.req_in = '0;
        check("bp_pend_in", 32'(bus.pend), 32'h0C0);
        @(negedge clk);
        check("bp_g0_id", 32'(bus.g0_id), 32'd8);
        check("bp_g1_id", 32'(bus.g1_id), 32'd7);
        check("bp_g1_valid", 32'(bus.g1_valid), 32'h1);
        @(negedge clk);
        check("bp_g1_retired", 32'(bus.g1_valid), 32'h0);
        check("bp_pend_080", 32'(bus.pend), 32'h080);
        @(negedge clk);
        check("bp_g0_held", 32'(bus.g0_valid), 32'h1);
        check("bp_g0_id_held", 32'(bus.g0_id), 32'd8);
        check("bp_pend_held", 32'(bus.pend), 32'h080);
        bus.g0_ready = 1'b1;
        @(negedge clk);
        check("bp_g0_done", 32'(bus.g0_valid), 32'h0);
        check("bp_pend_clr", 32'(bus.pend), 32'h0);
        check("bp_idle", 32'(bus.busy), 32'h0);

        // set-wins on a retiring bit, then flush during OFFER
        bus.g0_ready = 1'b0;
        bus.g1_ready = 1'b0;
        @(negedge clk);
        bus.req_in = 12'h0C0;
        @(negedge clk);
        bus.req_in = '0;
        @(negedge clk);
        bus.g1_ready = 1'b1;
        bus.req_in   = 12'h040;
        @(negedge clk);
        bus.g1_ready = 1'b0;
        bus.req_in   = '0;
        check("setwins_pend", 32'(bus.pend), 32'h0C0);
        check("setwins_g1_valid", 32'(bus.g1_valid), 32'h0);
        check("setwins_g0_valid", 32'(bus.g0_valid), 32'h1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush  = 1'b0;
        bus.req_in = 12'h001;
        check("flush_g0_valid", 32'(bus.g0_valid), 32'h0);
        check("flush_g1_valid", 32'(bus.g1_valid), 32'h0);
        check("flush_busy", 32'(bus.busy), 32'h1);
        check("flush_pend", 32'(bus.pend), 32'h0);
        @(negedge clk);
        bus.req_in = '0;
        check("flush_ignores_req", 32'(bus.pend), 32'h0);
        check("flush_to_idle", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("flush_no_grant", 32'(bus.g0_valid), 32'h0);

        // asynchronous reset in the middle of an offer
        bus.req_in = 12'h801;
        @(negedge clk);
        bus.req_in = '0;
        @(negedge clk);
        check("mid_offer_valid", 32'(bus.g0_valid), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pend", 32'(bus.pend), 32'h0);
        check("async_g0_valid", 32'(bus.g0_valid), 32'h0);
        check("async_g1_valid", 32'(bus.g1_valid), 32'h0);
        check("async_g0_id", 32'(bus.g0_id), 32'h0);
        check("async_g1_id", 32'(bus.g1_id), 32'h0);
        check("async_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'h0);
        check("post_rst_pend", 32'(bus.pend), 32'h0);

        // faulty encoder on pend=12'h010: flagged only when the checker is built in
        force_bad  = 1'b1;
        bus.req_in = 12'h010;
        @(negedge clk);
        bus.req_in = '0;
        @(negedge clk);
        check("chk_uses_encoder", 32'(bus.g0_id), 32'd3);
        check("chk_enc_err", 32'(bus.enc_err), 32'(CHK_EN));
        force_bad    = 1'b0;
        bus.g0_ready = 1'b1;
        wait_idle("chk");
        @(negedge clk);
        check("chk_enc_err_sticky", 32'(bus.enc_err), 32'(CHK_EN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
